// File: rtl/clk_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clk_phase_monitor
// Brief    : Checks the 3-phase one-hot ring for encoding and rotation order,
//            tracks lock, counts instruction cycles and reports faults.
// Revision : 1.0 - initial release
// ============================================================================
module clk_phase_monitor #(
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ph0,
  input  logic             ph1,
  input  logic             ph2,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [1:0] c_ACQ      = 2'd0;
  localparam logic [1:0] c_LOCKED   = 2'd1;
  localparam logic [1:0] c_FAULT    = 2'd2;
  localparam logic [3:0] c_LOCK_CNT = 4'(LOCK_CNT);
  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [3:0]       r_good_cnt;
  logic [1:0]       r_prev_idx;
  logic             r_prev_valid;
  logic [1:0]       r_phase;
  logic             r_err_pulse;
  logic             r_err_sticky;
  logic [7:0]       r_err_count;
  logic [CNT_W-1:0] r_instr_count;

  logic [2:0] w_s;
  logic       w_oh;
  logic [1:0] w_idx;
  logic [1:0] w_exp_idx;
  logic       w_good;
  logic       w_bad;

  assign w_s = {ph2, ph1, ph0};
  assign w_oh = (w_s == 3'b001) || (w_s == 3'b010) || (w_s == 3'b100);

  always_comb begin
    w_idx = 2'd0;
    case (w_s)
      3'b010:  w_idx = 2'd1;
      3'b100:  w_idx = 2'd2;
      default: w_idx = 2'd0;
    endcase
  end

  assign w_exp_idx = (r_prev_idx == 2'd2) ? 2'd0 : r_prev_idx + 2'd1;
  assign w_good    = w_oh && r_prev_valid && (w_idx == w_exp_idx);
  // A neutral sample (no valid predecessor) is neither good nor bad.
  assign w_bad     = !w_good && r_prev_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_ACQ;
      r_good_cnt    <= 4'd0;
      r_prev_idx    <= 2'd0;
      r_prev_valid  <= 1'b0;
      r_phase       <= 2'd3;
      r_err_pulse   <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_count   <= 8'd0;
      r_instr_count <= '0;
    end else begin
      r_phase      <= w_oh ? w_idx : 2'd3;
      r_prev_idx   <= w_idx;
      r_prev_valid <= w_oh;
      r_err_pulse  <= 1'b0;
      case (r_state)
        c_ACQ: begin
          if (clr_err) r_err_sticky <= 1'b0;
          if (w_good) begin
            if (r_good_cnt + 4'd1 == c_LOCK_CNT) begin
              r_state    <= c_LOCKED;
              r_good_cnt <= 4'd0;
            end else begin
              r_good_cnt <= r_good_cnt + 4'd1;
            end
          end else if (w_bad) begin
            r_good_cnt <= 4'd0;
          end
        end
        c_LOCKED: begin
          // The fault takes priority over a simultaneous clr_err.
          if (w_bad) begin
            r_state      <= c_FAULT;
            r_err_pulse  <= 1'b1;
            r_err_sticky <= 1'b1;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          end else begin
            if (clr_err) r_err_sticky <= 1'b0;
            if (w_good && w_idx == 2'd0) r_instr_count <= r_instr_count + c_ONE;
          end
        end
        c_FAULT: begin
          if (clr_err) begin
            r_state      <= c_ACQ;
            r_good_cnt   <= 4'd0;
            r_err_sticky <= 1'b0;
          end
        end
        default: r_state <= c_ACQ;
      endcase
    end
  end

  assign phase       = r_phase;
  assign locked      = (r_state == c_LOCKED);
  assign err_pulse   = r_err_pulse;
  assign err_sticky  = r_err_sticky;
  assign err_count   = r_err_count;
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_clk_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_phase_monitor
// Brief    : Self-checking bench for clk_phase_monitor (16-bit and 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_phase_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ph0 = 1'b0, ph1 = 1'b0, ph2 = 1'b0, clr_err = 1'b0;
  logic [1:0]  phase_a, phase_b;
  logic        locked_a, locked_b, pulse_a, pulse_b, sticky_a, sticky_b;
  logic [7:0]  errc_a, errc_b;
  logic [15:0] instr_a;
  logic [3:0]  instr_b;

  int n_pass = 0;
  int n_total = 0;

  clk_phase_monitor #(.LOCK_CNT(3), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .ph0(ph0), .ph1(ph1), .ph2(ph2), .clr_err(clr_err),
    .phase(phase_a), .locked(locked_a), .err_pulse(pulse_a), .err_sticky(sticky_a),
    .err_count(errc_a), .instr_count(instr_a)
  );

  clk_phase_monitor #(.LOCK_CNT(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .ph0(ph0), .ph1(ph1), .ph2(ph2), .clr_err(clr_err),
    .phase(phase_b), .locked(locked_b), .err_pulse(pulse_b), .err_sticky(sticky_b),
    .err_count(errc_b), .instr_count(instr_b)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers; mode 0=acquiring, 1=locked, 2=faulted.
  int m_mode, m_run, m_last, m_has_last, m_phase, m_pulse, m_sticky, m_errc, m_instr;
  int ring;

  task automatic m_reset();
    m_mode = 0; m_run = 0; m_last = 0; m_has_last = 0;
    m_phase = 3; m_pulse = 0; m_sticky = 0; m_errc = 0; m_instr = 0;
  endtask

  task automatic m_step(input logic [2:0] s, input bit c);
    int  pos;
    bit  onehot, good, bad;
    onehot = ($countones(s) == 1);
    pos = 0;
    for (int b = 0; b < 3; b++) if (s[b]) pos = b;
    good = onehot && (m_has_last != 0) && (pos == (m_last + 1) % 3);
    bad  = !good && (m_has_last != 0);
    m_phase = onehot ? pos : 3;
    m_pulse = 0;
    if (m_mode == 0) begin
      if (c) m_sticky = 0;
      if (good) begin
        m_run++;
        if (m_run == 3) begin m_mode = 1; m_run = 0; end
      end else if (bad) m_run = 0;
    end else if (m_mode == 1) begin
      if (bad) begin
        m_mode = 2; m_pulse = 1; m_sticky = 1;
        m_errc = (m_errc >= 255) ? 255 : m_errc + 1;
      end else begin
        if (c) m_sticky = 0;
        if (good && pos == 0) m_instr++;
      end
    end else if (c) begin
      m_mode = 0; m_run = 0; m_sticky = 0;
    end
    m_last = pos;
    m_has_last = onehot ? 1 : 0;
  endtask

  // Drive one sample, clock it in, then settle past the edge.
  task automatic cyc(input logic [2:0] s, input bit c);
    {ph2, ph1, ph0} = s;
    clr_err = c;
    @(posedge clk);
    m_step(s, c);
    #1;
  endtask

  task automatic ring_step(input bit c);
    cyc(3'b001 << ring, c);
    ring = (ring + 1) % 3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({phase_a, locked_a, pulse_a, sticky_a, errc_a, instr_a} !== {2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0})
      $display("FAIL reset_values: got phase=%0d locked=%0b pulse=%0b sticky=%0b errc=%0d instr=%0d, want 3/0/0/0/0/0",
               phase_a, locked_a, pulse_a, sticky_a, errc_a, instr_a);
    else n_pass++;
  endtask

  task automatic test_lock_sequence();
    logic [1:0] exp_ph [6];
    exp_ph = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    ring = 1;
    for (int k = 0; k < 6; k++) begin
      ring_step(1'b0);
      n_total++;
      if (phase_a !== exp_ph[k]) $display("FAIL seq_phase[%0d]: got %0d want %0d", k, phase_a, exp_ph[k]);
      else n_pass++;
      n_total++;
      if (locked_a !== (k >= 3)) $display("FAIL seq_locked[%0d]: got %0b want %0b", k, locked_a, (k >= 3));
      else n_pass++;
    end
    n_total++;
    if (instr_a !== 16'd1) $display("FAIL seq_instr: got %0d want 1", instr_a);
    else n_pass++;
  endtask

  task automatic test_not_onehot();
    cyc(3'b011, 1'b0);
    n_total++;
    if ({phase_a, locked_a, pulse_a, sticky_a, errc_a} !== {2'd3, 1'b0, 1'b1, 1'b1, 8'd1})
      $display("FAIL nonhot_fault: got phase=%0d locked=%0b pulse=%0b sticky=%0b errc=%0d, want 3/0/1/1/1",
               phase_a, locked_a, pulse_a, sticky_a, errc_a);
    else n_pass++;
    ring_step(1'b0);
    n_total++;
    if ({pulse_a, sticky_a, locked_a} !== 3'b010)
      $display("FAIL nonhot_after: got pulse=%0b sticky=%0b locked=%0b, want 0/1/0", pulse_a, sticky_a, locked_a);
    else n_pass++;
  endtask

  task automatic relock();
    ring_step(1'b1);
    repeat (3) ring_step(1'b0);
  endtask

  task automatic test_skip_and_recover();
    int ec;
    relock();
    n_total++;
    if ({locked_a, sticky_a} !== 2'b10) $display("FAIL relock: got locked=%0b sticky=%0b want 1/0", locked_a, sticky_a);
    else n_pass++;
    while (ring != 1) ring_step(1'b0);
    ring_step(1'b0);
    ec = int'(errc_a);
    cyc(3'b001, 1'b0);
    n_total++;
    if ({locked_a, pulse_a, errc_a} !== {1'b0, 1'b1, 8'(ec + 1)})
      $display("FAIL skip_fault: got locked=%0b pulse=%0b errc=%0d want 0/1/%0d", locked_a, pulse_a, errc_a, ec + 1);
    else n_pass++;
    ring = 1;
    relock();
    n_total++;
    if ({locked_a, sticky_a} !== 2'b10) $display("FAIL skip_recover: got locked=%0b sticky=%0b want 1/0", locked_a, sticky_a);
    else n_pass++;
  endtask

  task automatic test_bad_with_clear();
    cyc(3'b000, 1'b1);
    n_total++;
    if ({sticky_a, locked_a} !== 2'b10) $display("FAIL badclr_edge: got sticky=%0b locked=%0b want 1/0", sticky_a, locked_a);
    else n_pass++;
    ring = 0;
    repeat (5) ring_step(1'b0);
    n_total++;
    if ({sticky_a, locked_a} !== 2'b10) $display("FAIL badclr_held: got sticky=%0b locked=%0b want 1/0", sticky_a, locked_a);
    else n_pass++;
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 256; i++) begin
      ring_step(1'b1);
      repeat (4) ring_step(1'b0);
      cyc(3'b000, 1'b0);
    end
    n_total++;
    if (errc_a !== 8'd255) $display("FAIL errc_saturate: got %0d want 255", errc_a);
    else n_pass++;
    n_total++;
    if (errc_a !== 8'(m_errc)) $display("FAIL errc_model: got %0d want %0d", errc_a, m_errc);
    else n_pass++;
  endtask

  task automatic test_instr_wrap();
    int budget;
    do_reset();
    ring = 1;
    budget = 200;
    while (m_instr < 17 && budget > 0) begin
      ring_step(1'b0);
      budget--;
    end
    n_total++;
    if (budget == 0) $display("FAIL wrap_budget: got instr=%0d want 17 within budget", m_instr);
    else n_pass++;
    n_total++;
    if (instr_b !== 4'd1) $display("FAIL instr_wrap4: got %0d want 1", instr_b);
    else n_pass++;
    n_total++;
    if (instr_a !== 16'd17) $display("FAIL instr_16: got %0d want 17", instr_a);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    repeat (2) ring_step(1'b0);
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    n_total++;
    if ({phase_a, locked_a, pulse_a, sticky_a, errc_a, instr_a, instr_b} !==
        {2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0})
      $display("FAIL async_reset: got phase=%0d locked=%0b instr=%0d instr4=%0d, want 3/0/0/0",
               phase_a, locked_a, instr_a, instr_b);
    else n_pass++;
    #1;
    reset = 1'b0;
    ring = 1;
    repeat (4) ring_step(1'b0);
    n_total++;
    if (locked_a !== 1'b1) $display("FAIL async_relock: got locked=%0b want 1", locked_a);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] s;
    bit c;
    int errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) begin
        s = 3'($urandom_range(0, 7));
        cyc(s, c);
        ring = $urandom_range(0, 2);
      end else begin
        ring_step(c);
      end
      n_total++;
      if ({phase_a, locked_a, pulse_a, sticky_a, errc_a, instr_a, instr_b} !==
          {2'(m_phase), (m_mode == 1), 1'(m_pulse), 1'(m_sticky), 8'(m_errc), 16'(m_instr), 4'(m_instr)}) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got ph=%0d lk=%0b pu=%0b st=%0b ec=%0d ic=%0d ic4=%0d want ph=%0d lk=%0b pu=%0d st=%0d ec=%0d ic=%0d",
                   i, phase_a, locked_a, pulse_a, sticky_a, errc_a, instr_a, instr_b,
                   m_phase, (m_mode == 1), m_pulse, m_sticky, m_errc, m_instr);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    m_reset();
    ring = 1;
    test_reset();
    test_lock_sequence();
    test_not_onehot();
    test_skip_and_recover();
    test_bad_with_clear();
    test_err_saturate();
    test_instr_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
